// File: rtl/drum_voice_scheduler.sv
// Beat-driven step sequencer plus a voice mixer that time-shares one sample-ROM port.
// New PCM arrives 2*NUM_TRACKS+2 cycles after advance; an advance during a mix is dropped and flagged in overrun.
module drum_voice_scheduler #(
    parameter int NUM_TRACKS = 4,
    parameter int STEPS      = 8,
    parameter int SAMPLE_AW  = 12,
    parameter int SAMPLE_LEN = 4096
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst_n,
    input  logic                                    i_beat,
    input  logic                                    i_run,
    input  logic [NUM_TRACKS*STEPS-1:0]             i_pattern,
    input  logic                                    i_advance,
    output logic                                    o_rom_rd,
    output logic [$clog2(NUM_TRACKS)+SAMPLE_AW-1:0] o_rom_addr,
    input  logic [15:0]                             i_rom_data,
    output logic [23:0]                             o_pcm,
    output logic [$clog2(STEPS)-1:0]                o_step,
    output logic [NUM_TRACKS-1:0]                   o_active,
    output logic                                    o_overrun
);
    localparam int TW  = $clog2(NUM_TRACKS);
    localparam int SW  = $clog2(STEPS);
    localparam int AW  = TW + SAMPLE_AW;
    localparam int ACW = 16 + TW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_ACCUM  = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic [1:0]            r_state;
    logic [TW-1:0]         r_slot;
    logic signed [ACW-1:0] r_acc;
    logic                  r_fetched;
    logic [AW-1:0]         r_addr;
    logic [SAMPLE_AW-1:0]  r_ptr [NUM_TRACKS];

    logic [SW-1:0]         w_next_step;
    logic [NUM_TRACKS-1:0] w_trig;
    logic                  w_fetch_rd;
    logic [AW-1:0]         w_fetch_addr;
    logic [15:0]           w_sat;

    assign w_next_step  = o_step + SW'(1);
    assign w_fetch_rd   = (r_state == S_FETCH) && o_active[r_slot];
    assign w_fetch_addr = {r_slot, r_ptr[r_slot]};
    assign o_rom_rd     = w_fetch_rd;
    assign o_rom_addr   = w_fetch_rd ? w_fetch_addr : r_addr;

    always_comb begin
        w_trig = '0;
        if (i_run && i_beat) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                w_trig[t] = i_pattern[t*STEPS + int'(w_next_step)];
            end
        end
    end

    // In range exactly when all bits above bit 15 match the sign.
    always_comb begin
        if (r_acc[ACW-1:15] == '0 || r_acc[ACW-1:15] == '1) begin
            w_sat = r_acc[15:0];
        end else begin
            w_sat = r_acc[ACW-1] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_slot    <= '0;
            r_acc     <= '0;
            r_fetched <= 1'b0;
            r_addr    <= '0;
            o_pcm     <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (i_advance && r_state != S_IDLE) begin
                o_overrun <= 1'b1;
            end
            if (w_fetch_rd) begin
                r_addr <= w_fetch_addr;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_advance) begin
                        r_acc   <= '0;
                        r_slot  <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_fetched <= o_active[r_slot];
                    r_state   <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (r_fetched) begin
                        r_acc <= r_acc + {{TW{i_rom_data[15]}}, i_rom_data};
                    end
                    if (r_slot == TW'(NUM_TRACKS-1)) begin
                        r_state <= S_OUTPUT;
                    end else begin
                        r_slot  <= r_slot + TW'(1);
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    o_pcm   <= {w_sat, 8'h00};
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A trigger overrides the pointer advance of the voice being accumulated this cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_step   <= SW'(STEPS-1);
            o_active <= '0;
            for (int t = 0; t < NUM_TRACKS; t++) begin
                r_ptr[t] <= '0;
            end
        end else begin
            if (!i_run) begin
                o_step <= SW'(STEPS-1);
            end else if (i_beat) begin
                o_step <= w_next_step;
            end
            for (int t = 0; t < NUM_TRACKS; t++) begin
                if (w_trig[t]) begin
                    r_ptr[t]    <= '0;
                    o_active[t] <= 1'b1;
                end else if (r_state == S_ACCUM && r_fetched && r_slot == TW'(t)) begin
                    if (r_ptr[t] == SAMPLE_AW'(SAMPLE_LEN-1)) begin
                        r_ptr[t]    <= '0;
                        o_active[t] <= 1'b0;
                    end else begin
                        r_ptr[t] <= r_ptr[t] + SAMPLE_AW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: doc/drum_voice_scheduler.md
Name: drum_voice_scheduler

Overview:
- Step sequencer plus voice scheduler for the drum machine.
- On each tempo beat it advances an 8-step position and triggers the tracks whose pattern bit is set at that step.
- On each audio-driver sample request it time-shares one sample-ROM read port between all active voices, sums their samples, saturates the sum and presents a 24-bit PCM word to the audio driver's DAC inputs.

Parameters:
- NUM_TRACKS, 4, number of voices/tracks (power of 2).
- STEPS, 8, sequencer steps per bar (power of 2).
- SAMPLE_AW, 12, ROM address bits per track sample.
- SAMPLE_LEN, 4096, samples played per trigger (must be ≤ 2**SAMPLE_AW).

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- beat  in  1  one-cycle pulse per sequencer step, from the bpm clock divider.
- run  in  1  1 = sequencing enabled.
- pattern  in  NUM_TRACKS*STEPS  bit t*STEPS+s = track t plays at step s.
- advance  in  1  one-cycle pulse: audio driver has consumed the current sample.
- rom_rd  out  1  sample-ROM read strobe.
- rom_addr  out  log2(NUM_TRACKS)+SAMPLE_AW  {track, sample pointer}.
- rom_data  in  16  signed sample; valid the cycle after rom_rd.
- pcm  out  24  mixed output to dac_left/dac_right.
- step  out  log2(STEPS)  last played step.
- active  out  NUM_TRACKS  voice t is playing.
- overrun  out  1  sticky: advance arrived while a mix was in progress.

Behaviour:
- Reset (reset=0, asynchronous, immediate, including mid-mix):
  - pcm=0, step=STEPS-1, active=0, all pointers=0.
  - rom_rd=0, rom_addr=0, overrun=0, FSM=IDLE, accumulator=0.
- Sequencer:
  - run=0: step is forced synchronously to STEPS-1 and beat is ignored. Active voices finish normally.
  - run=1 and beat: step <= (step+1) mod STEPS, wrapping 7->0.
  - In the same edge, every track t with pattern[t*STEPS+new_step]=1 is triggered: ptr[t] <= 0, active[t] <= 1.
  - The first beat after run rises plays step 0.
- Retrigger: triggering an already-active voice restarts it at 0. No queueing.
- Mix FSM states: IDLE, FETCH, ACCUM, OUTPUT. Slot index t counts 0..NUM_TRACKS-1.
  - IDLE: when advance=1, clear accumulator, set t=0, go to FETCH. Otherwise stay in IDLE.
  - FETCH (one cycle):
    - If active[t]: rom_rd=1, rom_addr={t, ptr[t]}.
    - Else rom_rd=0 and rom_addr holds its value.
    - Go to ACCUM.
  - ACCUM (one cycle):
    - If voice t was active at FETCH: accumulator += sign-extended rom_data, using a 16+log2(NUM_TRACKS)-bit signed accumulator.
    - Then ptr[t]++. If ptr[t] was SAMPLE_LEN-1, active[t] <= 0 and ptr[t] <= 0.
    - If t=NUM_TRACKS-1 go to OUTPUT; else t++ and go to FETCH.
  - OUTPUT (one cycle):
    - pcm <= {sat16(accumulator), 8'h00}.
    - sat16 clamps to the range 16'h8000..16'h7FFF.
    - Go to IDLE.
- Fixed latency regardless of activity: advance sampled at cycle 0 gives a new pcm value visible at cycle 2*NUM_TRACKS+2 (cycle 10 with defaults). pcm holds between updates.
- With no voice active, the mix produces pcm=0.
- rom_rd is high for at most one cycle per active voice per mix, and only in FETCH.
- advance while FSM≠IDLE: ignored and overrun <= 1. overrun stays set until reset.
- Trigger in the same cycle as the ACCUM of the same voice: trigger wins. ptr=0, active=1, and the ACCUM pointer increment and end-of-sample clear are discarded. The accumulated sample is still added.
- Trigger for voice t after its FETCH slot: it takes effect from the next mix.
- Simultaneous beat and advance are both honoured in the same edge.

Test Plan:
- Reset values: assert reset=0 mid-mix with active=4'b1111 -> pcm=0, step=7, active=0, rom_rd=0, overrun=0, and the FSM returns to IDLE immediately, with no clock edge needed.
- Single trigger: pattern bit 0 set, run=1, one beat -> step=0, active=4'b0001. Then advance, with ROM returning 16'h1234 at address 0 -> exactly one rom_rd at cycle 1, addr 0, and pcm=24'h123400 at cycle 10.
- Saturation: all four tracks triggered, ROM returns 16'h7FFF -> pcm=24'h7FFF00. ROM returns 16'h8000 -> pcm=24'h800000. ROM returns +16'h1000 and -16'h1000 on two tracks each -> pcm=0.
- Step wrap and run gating: 9 beats with run=1 -> step sequence 0..7 then 0. Drop run -> step=7, and a further beat leaves step=7 and triggers nothing.
- End of sample: SAMPLE_LEN=4, trigger track 2 -> rom_addr pointers 0,1,2,3 on 4 successive mixes. active[2] clears after the 4th mix, and the 5th mix gives pcm=0 with no rom_rd.
- Overrun and retrigger: advance issued 3 cycles after a previous advance -> overrun=1 and no extra mix. Beat retriggering track 0 in track 0's ACCUM cycle -> the next mix reads addr {0, 0}.
